// File: rtl/sar8_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar8_pkg;

  localparam int SAR_WIDTH = 8;
  localparam logic [SAR_WIDTH-1:0] MSB_MASK = {1'b1, {(SAR_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRY  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Exactly one of the three comparator flags may be asserted for a sane compare.
  function automatic logic onehot3(input logic a, input logic b, input logic c);
    return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
  endfunction

endpackage

// File: rtl/sar8_ctrl_if.sv
// Comparator-loop bundle: request and flags flow into the controller, trial word and status flow out.
interface sar8_ctrl_if #(parameter int WIDTH = sar8_pkg::SAR_WIDTH);

  logic             start;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_gt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    output start, cmp_eq, cmp_lt, cmp_gt,
    input  trial, busy, done, result, found, err
  );

  modport slave (
    input  start, cmp_eq, cmp_lt, cmp_gt,
    output trial, busy, done, result, found, err
  );

endinterface

// File: rtl/sar8_ctrl.sv
// MSB-first binary search of an externally compared target, one bit decided per cycle;
// done pulses one cycle after the last decision, and start is ignored unless idle.
import sar8_pkg::*;

module sar8_ctrl #(
  parameter int WIDTH      = SAR_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  sar8_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic             err_q;

  logic             flags_ok;
  logic [WIDTH-1:0] trial_res_d;
  logic [WIDTH-1:0] ptr_d;
  logic [WIDTH-1:0] trial_d;

  // ptr_q is one-hot on the bit under decision, so resolving and advancing are pure masks.
  always_comb begin
    flags_ok    = onehot3(bus.cmp_eq, bus.cmp_lt, bus.cmp_gt);
    trial_res_d = bus.cmp_gt ? (trial_q & ~ptr_q) : trial_q;
    ptr_d       = ptr_q >> 1;
    trial_d     = trial_res_d | ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      ptr_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= TRY;
            trial_q <= TOP_BIT;
            ptr_q   <= TOP_BIT;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            trial_q <= '0;
          end
        end
        TRY: begin
          if (!flags_ok) begin
            err_q    <= 1'b1;
            result_q <= '0;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            trial_q  <= '0;
            ptr_q    <= '0;
          end else if (bus.cmp_eq && EARLY_EXIT) begin
            found_q  <= 1'b1;
            result_q <= trial_q;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            trial_q  <= '0;
            ptr_q    <= '0;
          end else begin
            if (bus.cmp_eq) begin
              found_q <= 1'b1;
            end
            if (ptr_q[0]) begin
              result_q <= trial_res_d;
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              trial_q  <= '0;
              ptr_q    <= '0;
            end else begin
              ptr_q   <= ptr_d;
              trial_q <= trial_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          trial_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          trial_q <= '0;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar8_ctrl.sv
// Two controllers (full search and early exit) closed through a behavioural comparator with fault injection.
module tb_sar8_ctrl;
  import sar8_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic       found;
    logic       err;
    int         done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic       start0, start1;
  logic [7:0] tgt0, tgt1;
  int         fcyc0 = -1;
  int         fcyc1 = -1;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] tq0[$];
  logic [7:0] tq1[$];

  sar8_ctrl_if #(.WIDTH(8)) b0();
  sar8_ctrl_if #(.WIDTH(8)) b1();

  sar8_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (.clk(clk), .rst_n(rst_n), .bus(b0));
  sar8_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b0.start  = start0;
  assign b0.cmp_eq = (cyc == fcyc0) ? 1'b0 : (b0.trial == tgt0);
  assign b0.cmp_lt = (cyc == fcyc0) ? 1'b1 : (b0.trial < tgt0);
  assign b0.cmp_gt = (cyc == fcyc0) ? 1'b1 : (b0.trial > tgt0);
  assign b1.start  = start1;
  assign b1.cmp_eq = (cyc == fcyc1) ? 1'b0 : (b1.trial == tgt1);
  assign b1.cmp_lt = (cyc == fcyc1) ? 1'b1 : (b1.trial < tgt1);
  assign b1.cmp_gt = (cyc == fcyc1) ? 1'b1 : (b1.trial > tgt1);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input logic busy, input logic done, input logic [7:0] trial,
                          input logic [7:0] result, input logic found, input logic err);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_trial"}, 32'(trial), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Reference: trial at decision d keeps the target's bits above the probed bit and sets the probed bit.
  // A full search always lands on the target; early exit stops at the first exact match.
  task automatic push_search(input int lane, input logic [7:0] t, input int k, input int fault_at,
                             output int lat);
    exp_t       e;
    logic [7:0] m;
    logic [7:0] above;
    logic [7:0] tr;
    logic [7:0] ones = 8'hFF;
    e.res   = t;
    e.found = 1'b0;
    e.err   = 1'b0;
    lat     = 8;
    for (int d = 1; d <= 8; d++) begin
      m     = MSB_MASK >> (d - 1);
      above = ones << (9 - d);
      tr    = (t & above) | m;
      if (lane == 0) tq0.push_back(tr); else tq1.push_back(tr);
      if (fault_at == d) begin
        e.res = 8'h00;
        e.err = 1'b1;
        lat   = d;
        break;
      end
      if (tr == t) begin
        e.found = 1'b1;
        if (lane == 1) begin
          lat = d;
          break;
        end
      end
    end
    e.done_cyc = k + lat;
    if (lane == 0) q0.push_back(e); else q1.push_back(e);
    if (fault_at > 0) begin
      if (lane == 0) fcyc0 = k + fault_at - 1; else fcyc1 = k + fault_at - 1;
    end
  endtask

  task automatic drive(input int lane, input bit s, input logic [7:0] t);
    if (lane == 0) begin start0 = s; tgt0 = t; end
    else begin start1 = s; tgt1 = t; end
  endtask

  task automatic drive_start(input int lane, input bit s);
    if (lane == 0) start0 = s; else start1 = s;
  endtask

  // Holds start high across a run of targets so each is accepted in the first idle cycle after done.
  task automatic run(input int lane, input logic [7:0] ts[$], input int fault_at, input bit repulse);
    int k;
    int lat;
    @(negedge clk);
    k = cyc + 1;
    drive(lane, 1'b1, ts[0]);
    for (int i = 0; i < ts.size(); i++) begin
      push_search(lane, ts[i], k, (i == 0) ? fault_at : 0, lat);
      while (cyc != k + lat + 1) begin
        @(negedge clk);
        if (repulse && cyc == k + 1) drive_start(lane, 1'b0);
        if (repulse && cyc == k + 2) drive_start(lane, 1'b1);
      end
      if (i + 1 < ts.size()) begin
        drive(lane, 1'b1, ts[i + 1]);
        k = k + lat + 2;
      end else begin
        drive_start(lane, 1'b0);
      end
    end
    repeat (3) @(negedge clk);
    fcyc0 = -1;
    fcyc1 = -1;
  endtask

  task automatic mon(input int lane, input logic busy, input logic done, input logic [7:0] trial,
                     input logic [7:0] result, input logic found, input logic err);
    exp_t       e;
    logic [7:0] et;
    bit         have;
    if (busy === 1'b1) begin
      have = 1'b0;
      if (lane == 0 && tq0.size() > 0) begin et = tq0.pop_front(); have = 1'b1; end
      else if (lane == 1 && tq1.size() > 0) begin et = tq1.pop_front(); have = 1'b1; end
      if (have) chk($sformatf("L%0d_trial", lane), 32'(trial), 32'(et));
      else begin
        checks++;
        failures++;
        $display("FAIL L%0d_busy_unexpected actual=busy trial=0x%0h required=idle", lane, trial);
      end
    end
    if (done === 1'b1) begin
      have = 1'b0;
      if (lane == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      else if (lane == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (have) begin
        chk($sformatf("L%0d_result", lane), 32'(result), 32'(e.res));
        chk($sformatf("L%0d_found", lane), 32'(found), 32'(e.found));
        chk($sformatf("L%0d_err", lane), 32'(err), 32'(e.err));
        chk($sformatf("L%0d_done_cycle", lane), 32'(cyc), 32'(e.done_cyc));
        chk($sformatf("L%0d_busy_at_done", lane), 32'(busy), 32'd0);
        chk($sformatf("L%0d_trial_at_done", lane), 32'(trial), 32'd0);
      end else begin
        checks++;
        failures++;
        $display("FAIL L%0d_done_unexpected actual=done required=no_done cyc=%0d", lane, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon(0, b0.busy, b0.done, b0.trial, b0.result, b0.found, b0.err);
      mon(1, b1.busy, b1.done, b1.trial, b1.result, b1.found, b1.err);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] tl[$];
    int         k;
    int         lat;
    int         n;
    int         fa;
    logic [7:0] t;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    tgt0   = 8'h00;
    tgt1   = 8'h00;
    @(negedge clk);
    #1;
    chk_zero("rst0", b0.busy, b0.done, b0.trial, b0.result, b0.found, b0.err);
    chk_zero("rst1", b1.busy, b1.done, b1.trial, b1.result, b1.found, b1.err);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    tl = '{8'hA5};         run(0, tl, 0, 1'b0);
    tl = '{8'h80};         run(1, tl, 0, 1'b0);
    tl = '{8'h00, 8'hFF};  run(0, tl, 0, 1'b0);
    tl = '{8'h00, 8'hFF};  run(1, tl, 0, 1'b0);
    tl = '{8'hA5};         run(0, tl, 3, 1'b0);
    tl = '{8'h5A};         run(0, tl, 0, 1'b1);
    tl = '{8'h5A, 8'h5A};  run(0, tl, 0, 1'b1);
    tl = '{8'h01, 8'h40};  run(1, tl, 0, 1'b1);

    // Abort a 0x3C search with reset just before its fourth decision.
    @(negedge clk);
    k = cyc + 1;
    drive(0, 1'b1, 8'h3C);
    push_search(0, 8'h3C, k, 0, lat);
    @(negedge clk);
    drive_start(0, 1'b0);
    while (cyc != k + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst0", b0.busy, b0.done, b0.trial, b0.result, b0.found, b0.err);
    tq0.delete();
    q0.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tl = '{8'h3C};         run(0, tl, 0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      tl.delete();
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 5))
          0:       t = 8'h00;
          1:       t = 8'hFF;
          default: t = 8'($urandom);
        endcase
        tl.push_back(t);
      end
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
      run(it % 2, tl, fa, 1'($urandom_range(0, 1)));
    end

    chk("pending", 32'(q0.size() + q1.size() + tq0.size() + tq1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar8_ctrl.md
Name: sar8_ctrl

Overview:
- Sequential successive-approximation controller that wraps the 8-bit magnitude comparator (cmp8) in a feedback loop.
- Drives the comparator's A operand with a trial word. The comparator's B operand is an externally held target.
- Consumes the comparator's eq/lt/gt flags and binary-searches the target value, MSB first, one bit per cycle.
- Used for code search, threshold calibration and as the digital half of SAR conversion.

Parameters:
- WIDTH, 8, trial/result width; must match comparator width.
- EARLY_EXIT, 1, 1 = finish as soon as eq is seen; 0 = always run WIDTH decision cycles.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a search; sampled only in IDLE.
- cmp_eq  in  1  comparator flag, trial == target.
- cmp_lt  in  1  comparator flag, trial < target.
- cmp_gt  in  1  comparator flag, trial > target.
- trial  out  WIDTH  word driven to comparator A input.
- busy  out  1  high while in TRY.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  search result; held until next accepted start.
- found  out  1  eq observed during the last search.
- err  out  1  flag-consistency violation during the last search.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; trial, result = 0; busy, done, found, err = 0; bit pointer cleared.
- States: IDLE, TRY, DONE.
- The comparator is combinational. Flags for the current trial are valid in the same cycle and are sampled at the rising edge.
- IDLE:
  - start=1 at edge k -> TRY.
  - trial = 1<<(WIDTH-1), i.e. 0x80; pointer = WIDTH-1.
  - found, err cleared; busy=1.
  - start=0 -> stay in IDLE; trial=0.
- TRY, per edge: check flags first.
  - Flags not exactly one-hot -> err=1, result=0, go to DONE. This takes priority over everything else.
  - cmp_eq=1 -> found=1. If EARLY_EXIT=1: result=trial, go to DONE.
  - cmp_gt=1 -> clear trial[pointer]; otherwise keep it.
  - pointer=0 -> result = resolved trial, go to DONE.
  - Otherwise pointer -= 1 and set the new trial[pointer].
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. trial=0.
- Latency from start edge k:
  - Full search: decisions at edges k+1..k+WIDTH; done high in the cycle after edge k+WIDTH; IDLE after edge k+WIDTH+1.
  - Early exit at decision j: done high in the cycle after edge k+j.
- start while busy or in DONE: ignored, no queueing.
- Back-to-back searches: start is accepted in the first IDLE cycle after DONE.
- Target 0:
  - No eq is ever seen; every bit is cleared.
  - result=0, found=0, err=0.
- Target all-ones: every decision is lt, or eq on the final bit. result=0xFF, found=1.
- Target must be stable while busy. If it changes, result is unspecified, but err detection still applies.
- Reset mid-search: immediate return to IDLE with reset values. No done pulse.
- Arithmetic: bit set/clear only; no carries or adders. The pointer is a one-hot or log2(WIDTH) down-counter that never wraps.

Decomposition:
- Package sar8_pkg holds:
  - state enum {IDLE, TRY, DONE};
  - default WIDTH constant = 8;
  - MSB mask constant.
- No sub-module inside the controller.
- Verification top sar8_loop instantiates sar8_ctrl plus cmp8 (A=trial, B=target). It maps cmp8 outputs i->cmp_eq, j->cmp_lt, k->cmp_gt.

Test Plan:
1. EARLY_EXIT=0, target 0xA5, start pulse at edge 0 -> trial sequence 80,C0,A0,B0,A8,A4,A6,A5; done high after edge 8; result=0xA5, found=1, err=0.
2. EARLY_EXIT=1, target 0x80 -> eq on first decision; done high after edge 1; result=0x80, found=1.
3. Target 0x00, then target 0xFF as a back-to-back second search -> result 0x00/found 0 (8 decisions), then 0xFF/found 1; second start accepted in the first cycle after done.
4. Flag fault: force cmp_lt=cmp_gt=1 at decision 3 -> done the following cycle, err=1, result=0x00.
5. Start asserted continuously and re-pulsed mid-search -> only one search runs; no restart; exactly one done pulse per accepted start.
6. rst_n low at decision 4 of a 0x3C search -> all outputs zero immediately with no done pulse; a new start then yields result=0x3C.
